// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result handshake and external full-adder bus
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_s;
  logic             fa_co;

  modport master (
    output start, op_a, op_b, cin, fa_s, fa_co,
    input  busy, done, sum, cout, fa_a, fa_b, fa_cin
  );

  modport slave (
    input  start, op_a, op_b, cin, fa_s, fa_co,
    output busy, done, sum, cout, fa_a, fa_b, fa_cin
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer driving an external 1-bit full adder
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH-1:0] s_next;

  assign last   = (cnt == CW'(WIDTH - 1));
  assign s_next = {bus.fa_s, s_sh[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.op_a;
            b_sh    <= bus.op_b;
            carry_q <= bus.cin;
            cnt     <= '0;
            s_sh    <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          s_sh    <= s_next;
          carry_q <= bus.fa_co;
          // Result registers update only on the final bit so no partial sum is ever visible.
          if (last) begin
            sum_q  <= s_next;
            cout_q <= bus.fa_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.sum    = sum_q;
  assign bus.cout   = cout_q;
  assign bus.fa_a   = (state_q == RUN) & a_sh[0];
  assign bus.fa_b   = (state_q == RUN) & b_sh[0];
  assign bus.fa_cin = (state_q == RUN) & carry_q;
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port op_a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 SHALL have port op_b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 SHALL have port cin  input  1  initial carry, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while bits are being processed (RUN).
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result of op_a+op_b+cin, low WIDTH bits.
REQ-011 SHALL have port cout  output  1  registered carry out of bit WIDTH-1.
REQ-012 SHALL have port fa_a  output  1  to external 1-bit full adder input A.
REQ-013 SHALL have port fa_b  output  1  to external full adder input B.
REQ-014 SHALL have port fa_cin  output  1  to external full adder carry-in C_{i-1}.
REQ-015 SHALL have port fa_s  input  1  from external full adder sum S.
REQ-016 SHALL have port fa_co  input  1  from external full adder carry-out C_i.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-018 IDLE: on an edge with start=1, SHALL load a_sh<=op_a, b_sh<=op_b, carry_q<=cin, bit counter<=0, clear sum shift register, go to RUN; start=0 stays IDLE.
REQ-019 RUN: fa_a SHALL be a_sh[0], fa_b SHALL be b_sh[0], fa_cin SHALL be carry_q, all driven from registers, no combinational path from fa_s/fa_co.
REQ-020 RUN, each edge: a_sh and b_sh shift right by 1, fa_s shifts into MSB of the sum shift register (right shift), carry_q<=fa_co, counter increments.
REQ-021 RUN SHALL last exactly WIDTH cycles; on the edge with counter==WIDTH-1, the SHALL load sum<=final shifted value (including that edge's fa_s), cout<=fa_co, and go to DONE.
REQ-022 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-023 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-024 Latency: start accepted at edge k -> busy high cycles k+1..k+WIDTH, done high cycle k+WIDTH+1; next start accepted earliest at edge k+WIDTH+2.
REQ-025 start SHALL be ignored in RUN and DONE; op_a/op_b/cin changes after acceptance SHALL NOT affect the result.
REQ-026 fa_a, fa_b, fa_cin SHALL be 0 in IDLE and DONE.
REQ-027 sum and cout SHALL hold their last value from DONE until the next RUN->DONE transition; they SHALL NOT show partial results.
REQ-028 Arithmetic: {cout,sum} SHALL equal op_a+op_b+cin modulo 2^(WIDTH+1), given a correct external full adder.
REQ-029 Counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap inside RUN.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, fa_a=fa_b=fa_cin=0, and clear all shift, carry and counter registers.
REQ-031 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; sum/cout SHALL read 0.
REQ-032 After rst_n rises, the first start SHALL be accepted on the first rising edge where start=1.

Verification (WIDTH=8, bench models the full adder behaviourally)
REQ-033 op_a=0x5A, op_b=0x3C, cin=0, start pulse -> busy 8 cycles, done pulse on cycle 9, sum=0x96, cout=0.
REQ-034 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1; fa_cin sequence over RUN = 0,1,1,1,1,1,1,1.
REQ-035 op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1; fa_cin=1 in all 8 RUN cycles.
REQ-036 start held high continuously with changing operands -> accepted only at IDLE edges, one done every 10 cycles, each result matches the operands sampled at its acceptance.
REQ-037 rst_n pulled low in the 4th RUN cycle -> busy, done, sum, cout, fa_* go to 0 at once; no done pulse; new start after release gives correct result.
REQ-038 op_a/op_b toggled every cycle during RUN -> sum/cout unchanged from the values latched at start.
